// File: rtl/car_pkg.sv
// Shared constants and enums for the counter/address register bank.
package car_pkg;

    localparam int unsigned CAR_WIDTH    = 16;
    localparam int unsigned CAR_NUM_REGS = 4;
    localparam int unsigned CAR_OFF_W    = 8;

    typedef enum logic {
        CAR_WRAP,
        CAR_SATURATE
    } car_mode_e;

    typedef enum logic [1:0] {
        STEP_NONE,
        STEP_INC,
        STEP_DEC
    } car_step_e;

endpackage

// File: rtl/strobe_edge_detect.sv
// Rising-edge detector for a level strobe; history resets high so clear release never fakes an edge.
module strobe_edge_detect (
    input  logic i_clock,
    input  logic i_clear,
    input  logic i_strobe,
    output logic o_rise
);

    logic r_prev;

    always_ff @(posedge i_clock) begin
        if (i_clear) begin
            r_prev <= 1'b1;
        end else begin
            r_prev <= i_strobe;
        end
    end

    assign o_rise = ~r_prev & i_strobe;

endmodule

// File: rtl/counter_address_register_bank.sv
// Bank of counter/address registers: bus load, edge-strobed inc/dec (wrap or saturate),
// combinational bus readback and a registered address with signed displacement.
module counter_address_register_bank
    import car_pkg::*;
#(
    parameter int unsigned WIDTH    = CAR_WIDTH,
    parameter int unsigned NUM_REGS = CAR_NUM_REGS,
    parameter int unsigned SEL_W    = $clog2(NUM_REGS),
    parameter int unsigned OFF_W    = CAR_OFF_W,
    parameter bit          SATURATE = 1'b0
) (
    input  logic             i_clock,
    input  logic             i_clear,
    input  logic [WIDTH-1:0] i_bus_in,
    input  logic             i_load_n,
    input  logic [SEL_W-1:0] i_load_sel,
    input  logic             i_inc,
    input  logic             i_dec,
    input  logic [SEL_W-1:0] i_step_sel,
    input  logic             i_a_bus_n,
    input  logic [SEL_W-1:0] i_bus_sel,
    output logic [WIDTH-1:0] o_bus_out,
    output logic             o_bus_oe,
    input  logic             i_a_addr_n,
    input  logic [SEL_W-1:0] i_addr_sel,
    input  logic [OFF_W-1:0] i_addr_offset,
    output logic [WIDTH-1:0] o_addr,
    output logic             o_addr_valid
);

    localparam car_mode_e Mode = SATURATE ? CAR_SATURATE : CAR_WRAP;

    logic [WIDTH-1:0] r_regs [NUM_REGS];
    logic [WIDTH-1:0] r_addr;
    logic             r_addr_valid;

    logic             w_inc_rise;
    logic             w_dec_rise;
    car_step_e        w_step;
    logic [WIDTH-1:0] w_bus_val;
    logic [WIDTH-1:0] w_step_src;
    logic [WIDTH-1:0] w_step_val;
    logic [WIDTH-1:0] w_addr_src;
    logic [WIDTH-1:0] w_offset_ext;

    strobe_edge_detect u_inc_edge (
        .i_clock  (i_clock),
        .i_clear  (i_clear),
        .i_strobe (i_inc),
        .o_rise   (w_inc_rise)
    );

    strobe_edge_detect u_dec_edge (
        .i_clock  (i_clock),
        .i_clear  (i_clear),
        .i_strobe (i_dec),
        .o_rise   (w_dec_rise)
    );

    always_comb begin
        w_step = STEP_NONE;
        if (w_inc_rise && !w_dec_rise) begin
            w_step = STEP_INC;
        end else if (w_dec_rise && !w_inc_rise) begin
            w_step = STEP_DEC;
        end
    end

    // Out-of-range selectors match no register, so reads fall back to zero.
    always_comb begin
        w_bus_val  = '0;
        w_step_src = '0;
        w_addr_src = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (i_bus_sel == SEL_W'(i)) begin
                w_bus_val = r_regs[i];
            end
            if (i_step_sel == SEL_W'(i)) begin
                w_step_src = r_regs[i];
            end
            if (i_addr_sel == SEL_W'(i)) begin
                w_addr_src = r_regs[i];
            end
        end
    end

    always_comb begin
        w_step_val = w_step_src;
        case (w_step)
            STEP_INC: begin
                if (!(Mode == CAR_SATURATE && (&w_step_src))) begin
                    w_step_val = w_step_src + WIDTH'(1);
                end
            end
            STEP_DEC: begin
                if (!(Mode == CAR_SATURATE && !(|w_step_src))) begin
                    w_step_val = w_step_src - WIDTH'(1);
                end
            end
            default: w_step_val = w_step_src;
        endcase
    end

    assign w_offset_ext = {{(WIDTH - OFF_W){i_addr_offset[OFF_W-1]}}, i_addr_offset};

    // Load beats step on the same register; the address uses the pre-update value.
    always_ff @(posedge i_clock) begin
        if (i_clear) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
            r_addr       <= '0;
            r_addr_valid <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (!i_load_n && (i_load_sel == SEL_W'(i))) begin
                    r_regs[i] <= i_bus_in;
                end else if ((w_step != STEP_NONE) && (i_step_sel == SEL_W'(i))) begin
                    r_regs[i] <= w_step_val;
                end
            end
            r_addr_valid <= ~i_a_addr_n;
            if (!i_a_addr_n) begin
                r_addr <= w_addr_src + w_offset_ext;
            end
        end
    end

    assign o_bus_out    = w_bus_val;
    assign o_bus_oe     = ~i_a_bus_n;
    assign o_addr       = r_addr;
    assign o_addr_valid = r_addr_valid;

endmodule

// File: tb/tb_counter_address_register_bank.sv
// Bench: wrap and saturate instances driven in lockstep from a vector table plus hand sequences.
module tb_counter_address_register_bank;

    typedef struct {
        logic        load_n;
        logic [1:0]  load_sel;
        logic [15:0] bus_in;
        logic        inc;
        logic        dec;
        logic [1:0]  step_sel;
        logic        a_addr_n;
        logic [1:0]  addr_sel;
        logic [7:0]  offset;
        logic [1:0]  chk_sel;
        logic [15:0] exp_w;
        logic [15:0] exp_s;
        logic [15:0] exp_addr;
    } vec_t;

    logic        clk = 1'b0;
    logic        clear;
    logic [15:0] bus_in;
    logic        load_n;
    logic [1:0]  load_sel;
    logic        inc;
    logic        dec;
    logic [1:0]  step_sel;
    logic        a_bus_n;
    logic [1:0]  bus_sel;
    logic        a_addr_n;
    logic [1:0]  addr_sel;
    logic [7:0]  addr_offset;

    logic [15:0] bus_out_w, bus_out_s, addr_w, addr_s;
    logic        bus_oe_w, bus_oe_s, addr_valid_w, addr_valid_s;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [15:0] sb [$];
    vec_t        vecs [$];

    always #5 clk = ~clk;

    counter_address_register_bank #(.SATURATE(1'b0)) dut_w (
        .i_clock       (clk),
        .i_clear       (clear),
        .i_bus_in      (bus_in),
        .i_load_n      (load_n),
        .i_load_sel    (load_sel),
        .i_inc         (inc),
        .i_dec         (dec),
        .i_step_sel    (step_sel),
        .i_a_bus_n     (a_bus_n),
        .i_bus_sel     (bus_sel),
        .o_bus_out     (bus_out_w),
        .o_bus_oe      (bus_oe_w),
        .i_a_addr_n    (a_addr_n),
        .i_addr_sel    (addr_sel),
        .i_addr_offset (addr_offset),
        .o_addr        (addr_w),
        .o_addr_valid  (addr_valid_w)
    );

    counter_address_register_bank #(.SATURATE(1'b1)) dut_s (
        .i_clock       (clk),
        .i_clear       (clear),
        .i_bus_in      (bus_in),
        .i_load_n      (load_n),
        .i_load_sel    (load_sel),
        .i_inc         (inc),
        .i_dec         (dec),
        .i_step_sel    (step_sel),
        .i_a_bus_n     (a_bus_n),
        .i_bus_sel     (bus_sel),
        .o_bus_out     (bus_out_s),
        .o_bus_oe      (bus_oe_s),
        .i_a_addr_n    (a_addr_n),
        .i_addr_sel    (addr_sel),
        .i_addr_offset (addr_offset),
        .o_addr        (addr_s),
        .o_addr_valid  (addr_valid_s)
    );

    function automatic vec_t mk(input logic ld_n, input logic [1:0] ld_sel,
                                input logic [15:0] din, input logic inc_v, input logic dec_v,
                                input logic [1:0] st_sel, input logic aa_n,
                                input logic [1:0] a_sel, input logic [7:0] off,
                                input logic [1:0] c_sel, input logic [15:0] ew,
                                input logic [15:0] es, input logic [15:0] ea);
        vec_t v;
        v.load_n = ld_n;   v.load_sel = ld_sel; v.bus_in = din;
        v.inc = inc_v;     v.dec = dec_v;       v.step_sel = st_sel;
        v.a_addr_n = aa_n; v.addr_sel = a_sel;  v.offset = off;
        v.chk_sel = c_sel; v.exp_w = ew;        v.exp_s = es; v.exp_addr = ea;
        return v;
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus_in = 16'h0; load_n = 1'b1; load_sel = 2'd0;
        inc = 1'b0; dec = 1'b0; step_sel = 2'd0;
        a_bus_n = 1'b1; bus_sel = 2'd0;
        a_addr_n = 1'b1; addr_sel = 2'd0; addr_offset = 8'h0;
    endtask

    task automatic check_reg(input string tag, input logic [1:0] sel,
                             input logic [15:0] ew, input logic [15:0] es);
        bus_sel = sel;
        #1;
        chk($sformatf("%s_w_reg%0d", tag, sel), bus_out_w, ew);
        chk($sformatf("%s_s_reg%0d", tag, sel), bus_out_s, es);
    endtask

    initial begin
        idle_inputs();
        // Reset: clear over a pending load with inc held high.
        clear = 1'b1; load_n = 1'b0; bus_in = 16'hAAAA; inc = 1'b1;
        tick();
        tick();
        for (int r = 0; r < 4; r++) check_reg("reset", 2'(r), 16'h0000, 16'h0000);
        chk("reset_addr_valid_w", {15'b0, addr_valid_w}, 16'h0);
        chk("reset_addr_valid_s", {15'b0, addr_valid_s}, 16'h0);
        chk("reset_addr_w", addr_w, 16'h0000);
        clear = 1'b0; load_n = 1'b1;
        tick();
        check_reg("post_clear_inc_held", 2'd0, 16'h0000, 16'h0000);

        //                ld_n sel din       inc dec st aa_n as off    cs exp_w     exp_s     exp_a
        vecs.push_back(mk(1, 0, 16'h0000, 0, 0, 0, 1, 0, 8'h00, 0, 16'h0000, 16'h0000, 16'h0));
        vecs.push_back(mk(0, 1, 16'hAAAA, 0, 0, 0, 1, 0, 8'h00, 1, 16'hAAAA, 16'hAAAA, 16'h0));
        vecs.push_back(mk(1, 0, 16'h0000, 0, 1, 1, 1, 0, 8'h00, 1, 16'hAAA9, 16'hAAA9, 16'h0));
        vecs.push_back(mk(1, 0, 16'h0000, 0, 0, 1, 1, 0, 8'h00, 1, 16'hAAA9, 16'hAAA9, 16'h0));
        vecs.push_back(mk(1, 0, 16'h0000, 0, 1, 1, 1, 0, 8'h00, 1, 16'hAAA8, 16'hAAA8, 16'h0));
        vecs.push_back(mk(1, 0, 16'h0000, 0, 1, 1, 1, 0, 8'h00, 1, 16'hAAA8, 16'hAAA8, 16'h0));
        vecs.push_back(mk(1, 0, 16'h0000, 0, 0, 1, 1, 0, 8'h00, 1, 16'hAAA8, 16'hAAA8, 16'h0));
        vecs.push_back(mk(1, 0, 16'h0000, 1, 0, 1, 1, 0, 8'h00, 1, 16'hAAA9, 16'hAAA9, 16'h0));
        vecs.push_back(mk(1, 0, 16'h0000, 0, 0, 1, 1, 0, 8'h00, 1, 16'hAAA9, 16'hAAA9, 16'h0));
        vecs.push_back(mk(1, 0, 16'h0000, 1, 0, 1, 1, 0, 8'h00, 1, 16'hAAAA, 16'hAAAA, 16'h0));
        vecs.push_back(mk(1, 0, 16'h0000, 0, 0, 1, 1, 0, 8'h00, 1, 16'hAAAA, 16'hAAAA, 16'h0));
        vecs.push_back(mk(1, 0, 16'h0000, 1, 0, 1, 1, 0, 8'h00, 1, 16'hAAAB, 16'hAAAB, 16'h0));
        vecs.push_back(mk(1, 0, 16'h0000, 0, 0, 1, 1, 0, 8'h00, 1, 16'hAAAB, 16'hAAAB, 16'h0));
        vecs.push_back(mk(0, 0, 16'hFFFF, 0, 0, 0, 1, 0, 8'h00, 0, 16'hFFFF, 16'hFFFF, 16'h0));
        vecs.push_back(mk(1, 0, 16'h0000, 1, 0, 0, 1, 0, 8'h00, 0, 16'h0000, 16'hFFFF, 16'h0));
        vecs.push_back(mk(1, 0, 16'h0000, 0, 0, 0, 1, 0, 8'h00, 0, 16'h0000, 16'hFFFF, 16'h0));
        vecs.push_back(mk(0, 0, 16'h0000, 0, 0, 0, 1, 0, 8'h00, 0, 16'h0000, 16'h0000, 16'h0));
        vecs.push_back(mk(1, 0, 16'h0000, 0, 1, 0, 1, 0, 8'h00, 0, 16'hFFFF, 16'h0000, 16'h0));
        vecs.push_back(mk(1, 0, 16'h0000, 0, 0, 0, 1, 0, 8'h00, 0, 16'hFFFF, 16'h0000, 16'h0));
        vecs.push_back(mk(1, 0, 16'h0000, 1, 1, 1, 1, 0, 8'h00, 1, 16'hAAAB, 16'hAAAB, 16'h0));
        vecs.push_back(mk(1, 0, 16'h0000, 0, 0, 1, 1, 0, 8'h00, 1, 16'hAAAB, 16'hAAAB, 16'h0));
        vecs.push_back(mk(0, 1, 16'h1234, 1, 0, 1, 1, 0, 8'h00, 1, 16'h1234, 16'h1234, 16'h0));
        vecs.push_back(mk(1, 0, 16'h0000, 0, 0, 1, 1, 0, 8'h00, 1, 16'h1234, 16'h1234, 16'h0));
        vecs.push_back(mk(0, 2, 16'h1000, 1, 0, 3, 1, 0, 8'h00, 2, 16'h1000, 16'h1000, 16'h0));
        vecs.push_back(mk(1, 0, 16'h0000, 0, 0, 3, 1, 0, 8'h00, 3, 16'h0001, 16'h0001, 16'h0));
        vecs.push_back(mk(1, 0, 16'h0000, 0, 0, 0, 0, 2, 8'hFE, 2, 16'h1000, 16'h1000, 16'h0FFE));
        vecs.push_back(mk(1, 0, 16'h0000, 0, 0, 0, 1, 0, 8'h00, 2, 16'h1000, 16'h1000, 16'h0));
        vecs.push_back(mk(0, 2, 16'hFFFF, 0, 0, 0, 1, 0, 8'h00, 2, 16'hFFFF, 16'hFFFF, 16'h0));
        vecs.push_back(mk(1, 0, 16'h0000, 1, 0, 2, 0, 2, 8'h01, 2, 16'h0000, 16'hFFFF, 16'h0000));
        vecs.push_back(mk(1, 0, 16'h0000, 0, 0, 2, 0, 1, 8'h80, 1, 16'h1234, 16'h1234, 16'h11B4));
        vecs.push_back(mk(1, 0, 16'h0000, 0, 0, 0, 1, 0, 8'h00, 0, 16'hFFFF, 16'h0000, 16'h0));

        foreach (vecs[i]) begin
            load_n = vecs[i].load_n;     load_sel = vecs[i].load_sel; bus_in = vecs[i].bus_in;
            inc = vecs[i].inc;           dec = vecs[i].dec;           step_sel = vecs[i].step_sel;
            a_addr_n = vecs[i].a_addr_n; addr_sel = vecs[i].addr_sel;
            addr_offset = vecs[i].offset;
            a_bus_n = i[0];
            if (!vecs[i].a_addr_n) sb.push_back(vecs[i].exp_addr);
            tick();
            check_reg($sformatf("v%0d", i), vecs[i].chk_sel, vecs[i].exp_w, vecs[i].exp_s);
            chk($sformatf("v%0d_bus_oe", i), {15'b0, bus_oe_w}, {15'b0, ~a_bus_n});
            chk($sformatf("v%0d_addr_valid_w", i), {15'b0, addr_valid_w},
                {15'b0, ~vecs[i].a_addr_n});
            chk($sformatf("v%0d_addr_valid_s", i), {15'b0, addr_valid_s},
                {15'b0, ~vecs[i].a_addr_n});
            if (addr_valid_w && sb.size() > 0) begin
                logic [15:0] e;
                e = sb.pop_front();
                chk($sformatf("v%0d_addr_w", i), addr_w, e);
                chk($sformatf("v%0d_addr_s", i), addr_s, e);
            end
        end
        chk("scoreboard_drained", 16'(sb.size()), 16'd0);

        // Clear mid-pulse: the rise, load and address in the clear cycle are all dropped.
        idle_inputs();
        step_sel = 2'd1;
        tick();
        clear = 1'b1; inc = 1'b1; load_n = 1'b0; load_sel = 2'd1; bus_in = 16'h5555;
        a_addr_n = 1'b0; addr_sel = 2'd1;
        tick();
        for (int r = 0; r < 4; r++) check_reg("midclr", 2'(r), 16'h0000, 16'h0000);
        chk("midclr_addr_valid", {15'b0, addr_valid_w}, 16'h0);
        chk("midclr_addr", addr_w, 16'h0000);
        clear = 1'b0; load_n = 1'b1; a_addr_n = 1'b1;
        tick();
        check_reg("midclr_release", 2'd1, 16'h0000, 16'h0000);
        inc = 1'b0;
        tick();
        inc = 1'b1;
        tick();
        check_reg("midclr_fresh_edge", 2'd1, 16'h0001, 16'h0001);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/counter_address_register_bank.md
# counter_address_register_bank

Parametrised bank of NUM_REGS counter/address registers for the pipelined CPU datapath. Each register can be loaded from the data bus, incremented or decremented by edge-triggered strobes, driven back onto the data bus, and presented on the address bus with a signed displacement. The block is the multi-channel successor to the single 16-bit counter/address register, adding an offset adder and a selectable wrap or saturate mode.

## Interface
- WIDTH, 16, register, bus and address width
- NUM_REGS, 4, number of registers (≥2)
- SEL_W, $clog2(NUM_REGS), selector width
- OFF_W, 8, signed address-offset width (< WIDTH)
- SATURATE, 0, 0 = wrap modulo 2^WIDTH, 1 = clamp at 0 / 2^WIDTH-1
- clock  in  1  rising-edge clock
- clear  in  1  reset, synchronous, active-high
- bus_in  in  WIDTH  data bus value for loads
- load_n  in  1  active-low load of register load_sel
- load_sel  in  SEL_W  load target
- inc  in  1  increment strobe, acts on 0→1 transition
- dec  in  1  decrement strobe, acts on 0→1 transition
- step_sel  in  SEL_W  inc/dec target
- a_bus_n  in  1  active-low assert to data bus
- bus_sel  in  SEL_W  register driven to data bus
- bus_out  out  WIDTH  reg[bus_sel], combinational
- bus_oe  out  1  = ~a_bus_n, combinational (top level owns the tristate)
- a_addr_n  in  1  active-low assert to address bus
- addr_sel  in  SEL_W  register used for address
- addr_offset  in  OFF_W  signed displacement
- addr  out  WIDTH  registered address
- addr_valid  out  1  registered; high when addr holds a fresh address

## Operation
- Reset values: all registers 0x0; addr 0x0; addr_valid 0; inc_prev/dec_prev 1 (idle-high, so release of clear never fakes an edge).
- Edge detect: inc_rise = ~inc_prev & inc, likewise dec; inc_prev <= inc and dec_prev <= dec every clock.
- Register update priority per register: clear > load > step.
- Load: load_n low → reg[load_sel] <= bus_in.
- Step on reg[step_sel]: inc_rise only → +1; dec_rise only → −1; both → no change.
- Load and step on the same register in the same cycle: load wins and the step is discarded. Different registers: both act.
- Wrap mode: 0xFFFF+1 → 0x0000, 0x0000−1 → 0xFFFF (WIDTH=16). Saturate mode: holds at 0xFFFF / 0x0000.
- Address: when a_addr_n is low, addr <= reg[addr_sel] + sign-extended addr_offset, always modulo 2^WIDTH (SATURATE does not apply) and addr_valid <= 1. Otherwise addr holds and addr_valid <= 0.
- The address reads the pre-update register value in any cycle that also loads or steps that register.
- Out-of-range selectors (NUM_REGS not a power of two): loads and steps are ignored, and reads return 0.

## Timing
- Load: value visible on bus_out or as an address source 1 clock after the load_n-low edge.
- Step: a strobe must be low for ≥1 sampled clock, then high. The update is applied at the first clock edge that samples it high. A strobe held high produces exactly one step.
- addr/addr_valid: 1-cycle latency from a_addr_n sampled low. Continuous a_addr_n low gives a new address every cycle.
- bus_out/bus_oe: zero latency (combinational from registers and a_bus_n).
- Clear mid-operation: clear wins at the next edge. A load, step or address issued in that cycle is dropped, and the edge state returns to idle-high.

## Structure
- Package car_pkg: default WIDTH/NUM_REGS/OFF_W constants, a mode enum (CAR_WRAP, CAR_SATURATE), and a step enum (STEP_NONE, STEP_INC, STEP_DEC).
- Sub-module strobe_edge_detect: one flop plus rising-edge output, reset to 1, instantiated for inc and dec.
- Register array, the step adder/saturation logic, and the offset adder stay in the top module.

## Test plan
- Clear held for 2 cycles with load_n low and bus_in=0xAAAA → all registers stay 0x0000, addr_valid=0; inc held high after clear gives no step.
- Load reg1=0xAAAA, then two dec low→high pulses on step_sel=1 → reg1=0xAAA8. Then three inc pulses → 0xAAAB, with a_bus_n low showing bus_out=0xAAAB, bus_oe=1.
- Wrap/saturate: reg0=0xFFFF plus an inc pulse → 0x0000 (SATURATE=0) or 0xFFFF (SATURATE=1). reg0=0x0000 plus a dec pulse → 0xFFFF or 0x0000.
- Same cycle: inc and dec rise together → no change; load_n low with an inc rise on the same register (bus_in=0x1234) → 0x1234; load reg2 with an inc on reg3 → both apply.
- Address: reg2=0x1000, addr_offset=0xFE (−2), a_addr_n low one cycle → next cycle addr=0x0FFE, addr_valid=1, then addr_valid=0. reg2=0xFFFF with offset 0x01 → addr=0x0000.
- Clear asserted mid-pulse (inc low, clear, then inc high) → registers 0, no step after clear release.
